// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with a programmable wait-state sequencer in front
// of the single-port data memory. It performs one transaction per grant: IDLE -> ACCESS -> DONE.
module mem_arbiter #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WORDS       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ready0,
  output logic        ready1,
  output logic        err,
  output logic [31:0] rdata,
  output logic        freeze0,
  output logic [1:0]  gnt,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_result
);

  localparam logic [31:0] ADDR_LO  = 32'(BASE_ADDR);
  localparam logic [31:0] ADDR_HI  = 32'(BASE_ADDR + 4 * WORDS - 4);
  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        last_gnt_reg, last_gnt_next;
  logic        owner_reg, owner_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        err_reg, err_next;
  logic [31:0] rdata_reg, rdata_next;

  // Requester chosen if a grant happens this cycle; on contention the one
  // that did not win last time gets the memory.
  logic        pick;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_ok;

  assign pick      = (req0 && req1) ? ~last_gnt_reg : req1;
  assign sel_we    = pick ? we1 : we0;
  assign sel_addr  = pick ? addr1 : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;
  assign addr_ok   = (sel_addr[1:0] == 2'b00) && (sel_addr >= ADDR_LO) && (sel_addr <= ADDR_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      last_gnt_reg <= 1'b1;
      owner_reg    <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      err_reg      <= 1'b0;
      rdata_reg    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_gnt_reg <= last_gnt_next;
      owner_reg    <= owner_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      err_reg      <= err_next;
      rdata_reg    <= rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_gnt_next = last_gnt_reg;
    owner_next    = owner_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    err_next      = err_reg;
    rdata_next    = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          owner_next    = pick;
          last_gnt_next = pick;
          we_next       = sel_we;
          addr_next     = sel_addr;
          wdata_next    = sel_wdata;
          cnt_next      = 4'd0;
          // Rejected addresses skip the memory entirely and complete with err.
          if (addr_ok) begin
            state_next = ACCESS;
            err_next   = 1'b0;
          end else begin
            state_next = DONE;
            err_next   = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_CNT) begin
          state_next = DONE;
          if (!we_reg) begin
            rdata_next = mem_result;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        err_next   = 1'b0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  logic [1:0] ready_vec;
  logic [1:0] gnt_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign ready_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
      assign gnt_vec[gi]   = (state_reg != IDLE) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign ready0      = ready_vec[0];
  assign ready1      = ready_vec[1];
  assign gnt         = gnt_vec;
  assign err         = err_reg;
  assign rdata       = rdata_reg;
  assign freeze0     = req0 & ~ready_vec[0];
  // Writes strobe once, in the final wait cycle, so an aborted write never lands.
  assign mem_read    = (state_reg == ACCESS) && !we_reg;
  assign mem_write   = (state_reg == ACCESS) && we_reg && (cnt_reg == LAST_CNT);
  assign mem_address = addr_reg;
  assign mem_data    = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 64-word memory, scoreboard of expected
// completions, table-driven transactions and hand-written multi-cycle sequences.
module tb_mem_arbiter;

  localparam int W    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ready0, ready1, err, freeze0, mem_read, mem_write;
  logic [31:0] rdata, mem_address, mem_data, mem_result;
  logic [1:0]  gnt;

  mem_arbiter #(.BASE_ADDR(BASE), .WORDS(64), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .err(err), .rdata(rdata),
    .freeze0(freeze0), .gnt(gnt),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_data(mem_data), .mem_result(mem_result)
  );

  always #5 clk = ~clk;

  // Memory model: word index from the latched byte address, combinational read.
  logic [31:0] mem [64];
  logic        load_mem = 1'b1;
  logic [5:0]  widx;
  assign widx       = 6'((mem_address - 32'(BASE)) >> 2);
  assign mem_result = mem[widx];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[3] <= 32'hDEAD_BEEF;
    end else if (mem_write) begin
      mem[widx] <= mem_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        id;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  task automatic push(input logic p, input logic e, input logic chk_rd,
                      input logic [31:0] rd, input int exp_cyc, input int tag);
    exp_t x;
    x.id = p; x.err = e; x.chk_rd = chk_rd; x.rdata = rd; x.cyc = exp_cyc; x.tag = tag;
    sbq.push_back(x);
  endtask

  // Completion monitor: every ready pulse is matched against the oldest expectation.
  exp_t got;
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt += int'(mem_read);
      wr_cnt += int'(mem_write);
      if (ready0 || ready1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ready", {30'd0, ready1, ready0}, 32'd0);
        end else begin
          got = sbq.pop_front();
          chk("ready_port", {30'd0, ready1, ready0}, got.id ? 32'd2 : 32'd1);
          chk("gnt_onehot", {30'd0, gnt}, got.id ? 32'd2 : 32'd1);
          chk("err", {31'd0, err}, {31'd0, got.err});
          chk("latency", 32'(cyc), 32'(got.cyc));
          if (got.chk_rd) chk("rdata", rdata, got.rdata);
          $display("txn tag=%0d port=%0d err=%0b rdata=%h cycle=%0d", got.tag, got.id, err, rdata, cyc);
        end
      end
    end
  end

  task automatic drive(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic release_req(input logic p);
    if (!p) req0 = 1'b0;
    else    req1 = 1'b0;
  endtask

  task automatic wait_ready(input logic p);
    int  i;
    bit  seen;
    i = 0;
    seen = 1'b0;
    while (!seen && i < 30) begin
      @(negedge clk);
      i++;
      if (p ? ready1 : ready0) seen = 1'b1;
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  task automatic do_txn(input vec_t v, input int tag);
    int rd0, wr0;
    @(posedge clk); #1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    drive(v.port, v.we, v.addr, v.wdata);
    push(v.port, v.err, v.chk_rd, v.rdata, cyc + (v.err ? 1 : W + 1), tag);
    wait_ready(v.port);
    @(posedge clk); #1;
    release_req(v.port);
    if (v.err) begin
      chk("illegal_no_read_strobe", 32'(rd_cnt - rd0), 32'd0);
      chk("illegal_no_write_strobe", 32'(wr_cnt - wr0), 32'd0);
    end
  endtask

  // Per-cycle strobe/freeze trace over cycles 0..3 of one transaction.
  task automatic run_traced(input logic p, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rd_exp,
                            input logic [3:0] exp_mr, input logic [3:0] exp_mw,
                            input logic [3:0] exp_fz, input int tag);
    logic [3:0] mr, mw, fz;
    @(posedge clk); #1;
    drive(p, w, a, d);
    push(p, 1'b0, !w, rd_exp, cyc + W + 1, tag);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mr[c] = mem_read;
      mw[c] = mem_write;
      fz[c] = freeze0;
    end
    @(posedge clk); #1;
    release_req(p);
    chk("trace_mem_read", {28'd0, mr}, {28'd0, exp_mr});
    chk("trace_mem_write", {28'd0, mw}, {28'd0, exp_mw});
    chk("trace_freeze0", {28'd0, fz}, {28'd0, exp_fz});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready0"}, {31'd0, ready0}, 32'd0);
    chk({tag, "_ready1"}, {31'd0, ready1}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'd0);
    chk({tag, "_mem_data"}, mem_data, 32'd0);
    chk({tag, "_freeze0"}, {31'd0, freeze0}, 32'd0);
  endtask

  vec_t vt[11];

  initial begin
    int start, n, i, wr0;

    vt[0]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vt[1]  = '{1'b0, 1'b1, 32'd1276, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 32'd1276, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001};
    vt[3]  = '{1'b0, 1'b1, 32'd1020, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 32'd1280, 32'h0,         1'b1, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 32'd1026, 32'h0BAD_BAD0, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 32'd1028, 32'h0,         1'b0, 1'b1, 32'h1000_0001};
    vt[7]  = '{1'b0, 1'b0, 32'd1276, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001};
    vt[8]  = '{1'b0, 1'b0, 32'd1024, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vt[9]  = '{1'b1, 1'b1, 32'd1022, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0};
    vt[10] = '{1'b1, 1'b0, 32'd1276, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    load_mem = 1'b0;
    rst = 1'b1;

    // Single read from port 0, then single write from port 1
    run_traced(1'b0, 1'b0, 32'd1036, 32'h0, 32'hDEAD_BEEF, 4'b0110, 4'b0000, 4'b0111, 100);
    run_traced(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 32'h0, 4'b0000, 4'b0100, 4'b0000, 101);

    // Table of legal/illegal transactions
    for (int k = 0; k < 11; k++) do_txn(vt[k], k);
    chk("mem63_after_illegal", mem[63], 32'hA5A5_0001);
    chk("mem0_after_illegal", mem[0], 32'h1234_5678);

    // Contention straight after reset: grant order 0,1,0,1, ready every W+2 cycles
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    start = cyc;
    drive(1'b0, 1'b0, 32'd1036, 32'h0);
    drive(1'b1, 1'b0, 32'd1024, 32'h0);
    push(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, start + 3,  200);
    push(1'b1, 1'b0, 1'b1, 32'h1234_5678, start + 7,  201);
    push(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, start + 11, 202);
    push(1'b1, 1'b0, 1'b1, 32'h1234_5678, start + 15, 203);
    n = 0;
    i = 0;
    while (n < 4 && i < 40) begin
      @(negedge clk);
      i++;
      if (ready0 || ready1) n++;
    end
    if (n < 4) chk("contention_timeout", 32'(n), 32'd4);
    @(posedge clk); #1;
    release_req(1'b0);
    release_req(1'b1);

    // Reset in the first ACCESS cycle of a write aborts it
    wr0 = wr_cnt;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    release_req(1'b1);
    check_all_zero("abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_no_write_strobe", 32'(wr_cnt - wr0), 32'd0);
    chk("abort_word_kept", mem[2], 32'h1000_0002);
    do_txn('{1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b1, 32'h1000_0002}, 300);
    do_txn('{1'b0, 1'b1, 32'd1040, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h0}, 301);
    do_txn('{1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b1, 32'h0F0F_0F0F}, 302);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
